sramlike_arb: RTL and testbench

SRAMLIKE_ARB -- requirements
Module: sramlike_arb

---
 rtl/sramlike_arb.sv | 152 +++++++++++++++
 tb/tb_sramlike_arb.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sramlike_arb.sv
// sramlike_arb
// Arbitrates NCH sram-like master channels onto one sram-like slave port.
// Accepted requests leave their channel index in an in-order tag FIFO so
// that slave data returns are steered back to the channel that issued them.
//
// Ports
//   clk, resetn            clock, asynchronous active-low reset
//   m_req/m_wr/m_size/...  per-channel request fields (channel i in slice i)
//   m_addrok, m_dataok     per-channel address-accept / data-return strobes
//   m_rdata                slave read data, broadcast to every channel
//   s_req/s_wr/s_size/...  slave request carrying the granted channel fields
//   s_addrok, s_dataok     slave address-accept / in-order data-return
//   s_rdata                slave read data
//   outstanding            accepted transactions not yet returned
//   err_unexp              sticky: data return seen with nothing outstanding
module sramlike_arb #(
    parameter int NCH     = 2,
    parameter int DEPTH   = 4,
    parameter int RR_MODE = 1
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [NCH-1:0]             m_req,
    input  logic [NCH-1:0]             m_wr,
    input  logic [2*NCH-1:0]           m_size,
    input  logic [32*NCH-1:0]          m_addr,
    input  logic [32*NCH-1:0]          m_wdata,
    output logic [NCH-1:0]             m_addrok,
    output logic [NCH-1:0]             m_dataok,
    output logic [31:0]                m_rdata,
    output logic                       s_req,
    output logic                       s_wr,
    output logic [1:0]                 s_size,
    output logic [31:0]                s_addr,
    output logic [31:0]                s_wdata,
    input  logic                       s_addrok,
    input  logic                       s_dataok,
    input  logic [31:0]                s_rdata,
    output logic [$clog2(DEPTH+1)-1:0] outstanding,
    output logic                       err_unexp
);

    localparam int IDX_W = $clog2(NCH);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic             lock_q;
    logic [IDX_W-1:0] gnt_q;
    logic [IDX_W-1:0] rr_ptr_q;
    logic [PTR_W-1:0] wptr_q;
    logic [PTR_W-1:0] rptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;
    logic [IDX_W-1:0] fifo_q [DEPTH];

    logic             arb_vld;
    logic [IDX_W-1:0] arb_idx;
    logic             gnt_vld;
    logic [IDX_W-1:0] gnt_idx;
    logic             full;
    logic             push;
    logic             pop;
    logic [IDX_W-1:0] head;
    logic [IDX_W-1:0] rr_ptr_d;

    // Scan channels starting at the rotation pointer (RR) or at 0 (fixed).
    always_comb begin
        int               c;
        logic [IDX_W-1:0] ci;
        arb_vld = 1'b0;
        arb_idx = '0;
        c       = 0;
        ci      = '0;
        for (int k = 0; k < NCH; k++) begin
            c = (RR_MODE != 0) ? int'(rr_ptr_q) + k : k;
            if (c >= NCH) c = c - NCH;
            ci = IDX_W'(c);
            if (!arb_vld && m_req[ci]) begin
                arb_vld = 1'b1;
                arb_idx = ci;
            end
        end
    end

    // A locked grant survives even if other channels start requesting.
    assign gnt_vld = lock_q | arb_vld;
    assign gnt_idx = lock_q ? gnt_q : arb_idx;
    assign full    = (cnt_q == CNT_W'(DEPTH));
    // resetn gate keeps s_req low while reset is held with m_req active.
    assign s_req   = resetn & gnt_vld & ~full;
    assign push    = s_req & s_addrok;
    // Pop decision uses the registered count, so a same-cycle push never
    // satisfies a return.
    assign pop     = s_dataok & (cnt_q != '0);
    assign head    = fifo_q[rptr_q];
    assign m_rdata = s_rdata;

    assign rr_ptr_d = (gnt_idx == IDX_W'(NCH-1)) ? '0 : gnt_idx + 1'b1;

    always_comb begin
        s_wr     = 1'b0;
        s_size   = '0;
        s_addr   = '0;
        s_wdata  = '0;
        m_addrok = '0;
        m_dataok = '0;
        for (int i = 0; i < NCH; i++) begin
            if (gnt_vld && gnt_idx == IDX_W'(i)) begin
                s_wr    = m_wr[i];
                s_size  = m_size[2*i +: 2];
                s_addr  = m_addr[32*i +: 32];
                s_wdata = m_wdata[32*i +: 32];
            end
            m_addrok[i] = push && (gnt_idx == IDX_W'(i));
            m_dataok[i] = pop && (head == IDX_W'(i));
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lock_q   <= 1'b0;
            gnt_q    <= '0;
            rr_ptr_q <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            // Lock holds while a request is presented but not yet accepted.
            lock_q <= s_req & ~s_addrok;
            if (s_req) gnt_q <= gnt_idx;
            if (push && RR_MODE != 0) rr_ptr_q <= rr_ptr_d;
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
            if (s_dataok && cnt_q == '0) err_q <= 1'b1;
        end
    end

    // Tag storage carries no reset; only entries between the pointers matter.
    always_ff @(posedge clk) begin
        if (push) fifo_q[wptr_q] <= gnt_idx;
    end

    assign outstanding = cnt_q;
    assign err_unexp   = err_q;

endmodule

// File: tb/tb_sramlike_arb.sv
module tb_sramlike_arb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [31:0] WD0 = 32'hD0D0_0000;
    localparam logic [31:0] WD1 = 32'hD1D1_1111;

    logic        resetn = 1'b1;
    logic [1:0]  m_req, fp_m_req;
    logic [1:0]  m_wr;
    logic [3:0]  m_size;
    logic [31:0] addr0, addr1;
    logic [63:0] m_addr, m_wdata;
    logic        s_addrok, s_dataok, fp_s_addrok, fp_s_dataok;
    logic [31:0] s_rdata;

    logic [1:0]  m_addrok, m_dataok, fp_m_addrok, fp_m_dataok;
    logic [31:0] m_rdata, s_addr, s_wdata, fp_m_rdata, fp_s_addr, fp_s_wdata;
    logic        s_req, s_wr, fp_s_req, fp_s_wr;
    logic [1:0]  s_size, fp_s_size;
    logic [2:0]  outstanding, fp_outstanding;
    logic        err_unexp, fp_err_unexp;

    assign m_addr  = {addr1, addr0};
    assign m_wdata = {WD1, WD0};
    assign m_wr    = 2'b10;
    assign m_size  = 4'b10_01;

    sramlike_arb #(.NCH(2), .DEPTH(4), .RR_MODE(1)) u_rr (
        .clk(clk), .resetn(resetn), .m_req(m_req), .m_wr(m_wr), .m_size(m_size),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_addrok(m_addrok), .m_dataok(m_dataok),
        .m_rdata(m_rdata), .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_addr(s_addr),
        .s_wdata(s_wdata), .s_addrok(s_addrok), .s_dataok(s_dataok), .s_rdata(s_rdata),
        .outstanding(outstanding), .err_unexp(err_unexp)
    );

    sramlike_arb #(.NCH(2), .DEPTH(4), .RR_MODE(0)) u_fp (
        .clk(clk), .resetn(resetn), .m_req(fp_m_req), .m_wr(m_wr), .m_size(m_size),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_addrok(fp_m_addrok), .m_dataok(fp_m_dataok),
        .m_rdata(fp_m_rdata), .s_req(fp_s_req), .s_wr(fp_s_wr), .s_size(fp_s_size),
        .s_addr(fp_s_addr), .s_wdata(fp_s_wdata), .s_addrok(fp_s_addrok),
        .s_dataok(fp_s_dataok), .s_rdata(s_rdata),
        .outstanding(fp_outstanding), .err_unexp(fp_err_unexp)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct { int ch; logic [31:0] val; } ent_t;
    ent_t aq[$], dq[$], faq[$], fdq[$];
    ent_t ea, ed, fa, fd;

    task automatic push_a(input int ch, input logic [31:0] a);
        aq.push_back('{ch, a});
    endtask
    task automatic push_d(input int ch, input logic [31:0] d);
        dq.push_back('{ch, d});
    endtask

    // Monitor for the round-robin instance.
    always @(negedge clk) begin
        if (s_req && s_addrok) begin
            if (aq.size() == 0) begin
                check("rr_unexpected_handshake", 64'(m_addrok), 64'(0));
                check("rr_unexpected_s_req", 64'(s_req), 64'(0));
            end else begin
                ea = aq.pop_front();
                check("rr_m_addrok", 64'(m_addrok), 64'(1) << ea.ch);
                check("rr_s_addr", 64'(s_addr), 64'(ea.val));
                check("rr_s_wr", 64'(s_wr), 64'(ea.ch == 1));
                check("rr_s_size", 64'(s_size), (ea.ch == 1) ? 64'h2 : 64'h1);
                check("rr_s_wdata", 64'(s_wdata), (ea.ch == 1) ? 64'(WD1) : 64'(WD0));
            end
        end else begin
            check("rr_m_addrok_idle", 64'(m_addrok), 64'(0));
        end
        if (m_dataok != 2'b00) begin
            if (dq.size() == 0) begin
                check("rr_unexpected_dataok", 64'(m_dataok), 64'(0));
            end else begin
                ed = dq.pop_front();
                check("rr_m_dataok", 64'(m_dataok), 64'(1) << ed.ch);
                check("rr_m_rdata", 64'(m_rdata), 64'(ed.val));
            end
        end
    end

    // Monitor for the fixed-priority instance.
    always @(negedge clk) begin
        if (fp_s_req && fp_s_addrok) begin
            if (faq.size() == 0) begin
                check("fp_unexpected_handshake", 64'(fp_m_addrok), 64'(0));
            end else begin
                fa = faq.pop_front();
                check("fp_m_addrok", 64'(fp_m_addrok), 64'(1) << fa.ch);
                check("fp_s_addr", 64'(fp_s_addr), 64'(fa.val));
            end
        end else begin
            check("fp_m_addrok_idle", 64'(fp_m_addrok), 64'(0));
        end
        if (fp_m_dataok != 2'b00) begin
            if (fdq.size() == 0) begin
                check("fp_unexpected_dataok", 64'(fp_m_dataok), 64'(0));
            end else begin
                fd = fdq.pop_front();
                check("fp_m_dataok", 64'(fp_m_dataok), 64'(1) << fd.ch);
                check("fp_m_rdata", 64'(fp_m_rdata), 64'(fd.val));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        cyc();
        resetn = 1'b1;
        check("rst_err_clear", 64'(err_unexp), 64'(0));
        check("rst_out_clear", 64'(outstanding), 64'(0));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        m_req = 2'b11; fp_m_req = 2'b00;
        s_addrok = 1'b1; s_dataok = 1'b0; s_rdata = '0;
        fp_s_addrok = 1'b0; fp_s_dataok = 1'b0;
        addr0 = 32'h1000; addr1 = 32'h2000;
        #2 resetn = 1'b0;
        repeat (2) cyc();
        check("rst_s_req", 64'(s_req), 64'(0));
        check("rst_m_addrok", 64'(m_addrok), 64'(0));
        check("rst_m_dataok", 64'(m_dataok), 64'(0));
        check("rst_outstanding", 64'(outstanding), 64'(0));
        check("rst_err_unexp", 64'(err_unexp), 64'(0));
        m_req = 2'b00; s_addrok = 1'b0; resetn = 1'b1;
        cyc();

        // Reset mid-operation drops the tag; the late return is unexpected.
        m_req = 2'b01; s_addrok = 1'b1; push_a(0, 32'h1000);
        cyc();
        m_req = 2'b00; s_addrok = 1'b0;
        check("one_outstanding", 64'(outstanding), 64'(1));
        resetn = 1'b0;
        #1 check("async_rst_outstanding", 64'(outstanding), 64'(0));
        cyc();
        resetn = 1'b1;
        s_dataok = 1'b1; s_rdata = 32'hDEAD;
        cyc();
        s_dataok = 1'b0;
        check("unexp_err", 64'(err_unexp), 64'(1));
        check("unexp_outstanding", 64'(outstanding), 64'(0));
        do_reset();

        // Round-robin alternation until the tag FIFO fills.
        m_req = 2'b11; s_addrok = 1'b1;
        push_a(0, 32'h1000); push_a(1, 32'h2000); push_a(0, 32'h1000); push_a(1, 32'h2000);
        repeat (4) cyc();
        check("full_s_req", 64'(s_req), 64'(0));
        check("full_outstanding", 64'(outstanding), 64'(4));
        s_dataok = 1'b1; s_rdata = 32'h11; push_d(0, 32'h11);
        cyc();
        s_dataok = 1'b0;
        check("after_pop_outstanding", 64'(outstanding), 64'(3));
        check("after_pop_s_req", 64'(s_req), 64'(1));
        push_a(0, 32'h1000);
        cyc();
        m_req = 2'b00;
        check("refill_outstanding", 64'(outstanding), 64'(4));
        for (int i = 0; i < 4; i++) begin
            s_dataok = 1'b1; s_rdata = 32'h21 + i;
            push_d((i % 2 == 0) ? 1 : 0, 32'h21 + i);
            cyc();
        end
        s_dataok = 1'b0;
        check("drain_outstanding", 64'(outstanding), 64'(0));

        // In-order returns steered to the issuing channel.
        m_req = 2'b10; addr1 = 32'h100; push_a(1, 32'h100);
        cyc();
        m_req = 2'b01; addr0 = 32'h200; push_a(0, 32'h200);
        cyc();
        m_req = 2'b00; s_dataok = 1'b1; s_rdata = 32'hAAAA; push_d(1, 32'hAAAA);
        cyc();
        s_rdata = 32'hBBBB; push_d(0, 32'hBBBB);
        cyc();
        s_dataok = 1'b0;
        check("order_outstanding", 64'(outstanding), 64'(0));

        // Simultaneous push and pop.
        m_req = 2'b01; push_a(0, 32'h200);
        cyc();
        m_req = 2'b10; s_dataok = 1'b1; s_rdata = 32'hC0;
        push_a(1, 32'h100); push_d(0, 32'hC0);
        cyc();
        check("pushpop_outstanding", 64'(outstanding), 64'(1));
        m_req = 2'b00; s_rdata = 32'hC1; push_d(1, 32'hC1);
        cyc();
        s_dataok = 1'b0;
        check("pushpop_drain", 64'(outstanding), 64'(0));

        // Lock on channel 1 while channel 0 (pointer target) starts requesting.
        addr0 = 32'h1000; addr1 = 32'h2000; s_addrok = 1'b0; m_req = 2'b10;
        #1 check("lock1_s_addr_c1", 64'(s_addr), 64'h2000);
        cyc();
        m_req = 2'b11;
        #1 check("lock1_s_addr_c2", 64'(s_addr), 64'h2000);
        cyc();
        check("lock1_s_addr_c3", 64'(s_addr), 64'h2000);
        s_addrok = 1'b1; push_a(1, 32'h2000);
        cyc();
        push_a(0, 32'h1000);
        cyc();
        // Lock on channel 0 while channel 1 (pointer target) starts requesting.
        m_req = 2'b01; s_addrok = 1'b0;
        #1 check("lock0_s_addr_c1", 64'(s_addr), 64'h1000);
        cyc();
        m_req = 2'b11;
        #1 check("lock0_s_addr_c2", 64'(s_addr), 64'h1000);
        cyc();
        check("lock0_s_addr_c3", 64'(s_addr), 64'h1000);
        check("lock0_s_req", 64'(s_req), 64'(1));
        s_addrok = 1'b1; push_a(0, 32'h1000);
        cyc();
        push_a(1, 32'h2000);
        cyc();
        m_req = 2'b00; s_addrok = 1'b0;
        check("lock_outstanding", 64'(outstanding), 64'(4));
        push_d(1, 32'h51); push_d(0, 32'h52); push_d(0, 32'h53); push_d(1, 32'h54);
        for (int i = 0; i < 4; i++) begin
            s_dataok = 1'b1; s_rdata = 32'h51 + i;
            cyc();
        end
        s_dataok = 1'b0;

        // Same-cycle push does not satisfy a return on an empty FIFO.
        m_req = 2'b01; s_addrok = 1'b1; s_dataok = 1'b1; s_rdata = 32'hEE;
        push_a(0, 32'h1000);
        cyc();
        m_req = 2'b00; s_addrok = 1'b0; s_dataok = 1'b0;
        check("samecyc_err", 64'(err_unexp), 64'(1));
        check("samecyc_outstanding", 64'(outstanding), 64'(1));
        s_dataok = 1'b1; s_rdata = 32'hD0; push_d(0, 32'hD0);
        cyc();
        s_dataok = 1'b0;
        check("samecyc_drain", 64'(outstanding), 64'(0));

        // Fixed priority: channel 0 wins every cycle.
        fp_m_req = 2'b11; fp_s_addrok = 1'b1;
        for (int i = 0; i < 4; i++) faq.push_back('{0, 32'h1000});
        repeat (4) cyc();
        check("fp_full_s_req", 64'(fp_s_req), 64'(0));
        check("fp_full_outstanding", 64'(fp_outstanding), 64'(4));
        fp_m_req = 2'b00;
        for (int i = 0; i < 4; i++) begin
            fp_s_dataok = 1'b1; s_rdata = 32'h30 + i;
            fdq.push_back('{0, 32'h30 + i});
            cyc();
        end
        fp_s_dataok = 1'b0;
        fp_m_req = 2'b10; faq.push_back('{1, 32'h2000});
        cyc();
        fp_m_req = 2'b00; fp_s_addrok = 1'b0;
        check("fp_c1_outstanding", 64'(fp_outstanding), 64'(1));
        fp_s_dataok = 1'b1; s_rdata = 32'h40; fdq.push_back('{1, 32'h40});
        cyc();
        fp_s_dataok = 1'b0;
        check("fp_drain", 64'(fp_outstanding), 64'(0));
        check("fp_err_unexp", 64'(fp_err_unexp), 64'(0));

        cyc();
        check("rr_addr_queue_empty", 64'(aq.size()), 64'(0));
        check("rr_data_queue_empty", 64'(dq.size()), 64'(0));
        check("fp_addr_queue_empty", 64'(faq.size()), 64'(0));
        check("fp_data_queue_empty", 64'(fdq.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
